// File: rtl/inequality_arbiter.sv
// Round-robin arbiter sharing one combinational Inequality comparator between two
// requesters: launches an operand, waits SETTLE cycles, captures the result per requester.
module inequality_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic [3:0] NUM0,
  input  logic [3:0] NUM1,
  output logic [1:0] GNT,
  output logic       BUSY,
  output logic [3:0] CMP_NUM,
  input  logic [2:0] CMP_OUT,
  output logic [1:0] DONE,
  output logic [2:0] RES0,
  output logic [2:0] RES1,
  output logic [7:0] SRV_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

  localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [3:0]  CNT_INIT   = 4'(SETTLE_EFF - 1);

  state_t     state;
  logic       last;
  logic       owner;
  logic [3:0] cnt;
  logic [1:0] elig;
  logic       win;

  // A requester whose DONE is high this cycle is not eligible, so a continuously
  // requesting client yields to a waiting peer.
  always_comb begin
    elig = REQ & ~DONE;
    win  = (elig == 2'b11) ? ~last : elig[1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      cnt     <= '0;
      GNT     <= '0;
      BUSY    <= 1'b0;
      DONE    <= '0;
      CMP_NUM <= '0;
      RES0    <= '0;
      RES1    <= '0;
      SRV_CNT <= '0;
    end else begin
      DONE <= '0;
      unique case (state)
        ST_IDLE: begin
          if (elig != 2'b00) begin
            owner   <= win;
            CMP_NUM <= win ? NUM1 : NUM0;
            GNT     <= win ? 2'b10 : 2'b01;
            cnt     <= CNT_INIT;
            BUSY    <= 1'b1;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_CAPTURE;
          else           cnt   <= cnt - 4'd1;
        end
        ST_CAPTURE: begin
          if (owner) RES1 <= CMP_OUT;
          else       RES0 <= CMP_OUT;
          DONE    <= owner ? 2'b10 : 2'b01;
          last    <= owner;
          SRV_CNT <= SRV_CNT + 8'd1;
          GNT     <= '0;
          BUSY    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inequality_arbiter.sv
// Self-checking bench for inequality_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-schedule reference model.
module tb_inequality_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req, gnt, done;
  logic [3:0] num0, num1, cmp_num;
  logic       busy;
  logic [2:0] cmp_out, res0, res1;
  logic [7:0] srv_cnt;

  logic [1:0] req_s, gnt_s, done_s;
  logic [3:0] num0_s, num1_s, cmp_num_s;
  logic       busy_s;
  logic [2:0] cmp_out_s, res0_s, res1_s;
  logic [7:0] srv_cnt_s;

  // Stand-in comparator: arbitrary lookup table with the known point NUM=6 -> 3'b101.
  logic [2:0] tbl [16];
  logic       glitch_s;
  logic [2:0] junk;
  assign cmp_out   = tbl[cmp_num];
  assign cmp_out_s = glitch_s ? junk : tbl[cmp_num_s];

  inequality_arbiter #(.SETTLE(1)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .NUM0(num0), .NUM1(num1), .GNT(gnt), .BUSY(busy),
    .CMP_NUM(cmp_num), .CMP_OUT(cmp_out), .DONE(done), .RES0(res0), .RES1(res1),
    .SRV_CNT(srv_cnt));

  inequality_arbiter #(.SETTLE(3)) dut3 (
    .CLK(clk), .RST(rst), .REQ(req_s), .NUM0(num0_s), .NUM1(num1_s), .GNT(gnt_s),
    .BUSY(busy_s), .CMP_NUM(cmp_num_s), .CMP_OUT(cmp_out_s), .DONE(done_s), .RES0(res0_s),
    .RES1(res1_s), .SRV_CNT(srv_cnt_s));

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_s = '0; glitch_s = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; num0 = 4'd3; num1 = 4'd4;
    step();
    total++;
    if ({gnt, busy, done, cmp_num, res0, res1, srv_cnt} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b busy=%b done=%b num=%h r0=%b r1=%b cnt=%0d exp all 0",
               gnt, busy, done, cmp_num, res0, res1, srv_cnt);
    end
    total++;
    if ({gnt_s, busy_s, done_s, srv_cnt_s} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs_s got gnt=%b busy=%b done=%b cnt=%0d exp 0", gnt_s, busy_s, done_s, srv_cnt_s);
    end
    rst = 1'b0; req = '0;
    step();
    total++;
    if ({gnt, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got gnt=%b busy=%b exp 00 0", gnt, busy);
    end
  endtask

  task automatic test_single();
    num0 = 4'd6; req = 2'b01;
    step();
    req = '0;
    total++;
    if ({gnt, cmp_num, busy} !== {2'b01, 4'd6, 1'b1}) begin
      bad++;
      $display("FAIL single_launch got gnt=%b num=%0d busy=%b exp 01 6 1", gnt, cmp_num, busy);
    end
    step();
    total++;
    if (done !== 2'b00) begin
      bad++;
      $display("FAIL single_early_done got=%b exp=00", done);
    end
    step();
    total++;
    if ({res0, done, srv_cnt, res1} !== {3'b101, 2'b01, 8'd1, 3'b000}) begin
      bad++;
      $display("FAIL single_capture got r0=%b done=%b cnt=%0d r1=%b exp 101 01 1 000", res0, done, srv_cnt, res1);
    end
    step();
    total++;
    if ({done, busy} !== 3'b000) begin
      bad++;
      $display("FAIL single_done_clear got done=%b busy=%b exp 00 0", done, busy);
    end
  endtask

  task automatic test_tie();
    logic [1:0] eg [9];
    logic [1:0] ed [9];
    eg = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    ed = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    do_reset();
    num0 = 4'd6; num1 = 4'd9; req = 2'b11;
    for (int c = 1; c <= 9; c++) begin
      step();
      total++;
      if ({gnt, done} !== {eg[c-1], ed[c-1]}) begin
        bad++;
        $display("FAIL tie_cycle%0d got gnt=%b done=%b exp gnt=%b done=%b", c, gnt, done, eg[c-1], ed[c-1]);
      end
      if (c == 6) begin
        total++;
        if (res1 !== tbl[9]) begin
          bad++;
          $display("FAIL tie_res1 got=%b exp=%b", res1, tbl[9]);
        end
      end
      if (c == 9) req = '0;
    end
    step();
    total++;
    if ({srv_cnt, busy, res0} !== {8'd3, 1'b0, 3'b101}) begin
      bad++;
      $display("FAIL tie_end got cnt=%0d busy=%b r0=%b exp 3 0 101", srv_cnt, busy, res0);
    end
  endtask

  task automatic test_settle();
    num1_s = 4'd5; req_s = 2'b10;
    step();
    total++;
    if ({gnt_s, cmp_num_s} !== {2'b10, 4'd5}) begin
      bad++;
      $display("FAIL settle_launch got gnt=%b num=%0d exp 10 5", gnt_s, cmp_num_s);
    end
    req_s = '0; num1_s = 4'hA; glitch_s = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      junk = tbl[5] ^ 3'($urandom_range(1, 7));
      step();
      if (c == 4) glitch_s = 1'b0;
      else junk = tbl[5] ^ 3'($urandom_range(1, 7));
      total++;
      if ({done_s, busy_s} !== {2'b00, 1'b1}) begin
        bad++;
        $display("FAIL settle_wait%0d got done=%b busy=%b exp 00 1", c, done_s, busy_s);
      end
    end
    step();
    total++;
    if ({done_s, res1_s, srv_cnt_s, busy_s} !== {2'b10, tbl[5], 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL settle_capture got done=%b r1=%b cnt=%0d busy=%b exp 10 %b 1 0",
               done_s, res1_s, srv_cnt_s, busy_s, tbl[5]);
    end
  endtask

  task automatic test_drop();
    num0 = 4'd0; req = 2'b01;
    step(); req = '0; step(); step();
    total++;
    if (res0 !== 3'b010) begin
      bad++;
      $display("FAIL drop_pre got=%b exp=010", res0);
    end
    step();
    num0 = 4'd6; req = 2'b01;
    step();
    num0 = 4'd0; req = '0;
    step(); step();
    total++;
    if ({res0, done} !== {3'b101, 2'b01}) begin
      bad++;
      $display("FAIL drop_capture got r0=%b done=%b exp 101 01", res0, done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    num0 = 4'd6; req = 2'b01;
    step();
    req = '0; rst = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy got=%b exp=1", busy);
    end
    step();
    rst = 1'b0;
    total++;
    if ({gnt, busy, done, cmp_num, res0, res1, srv_cnt} !== 23'd0) begin
      bad++;
      $display("FAIL rstmid_values got gnt=%b busy=%b done=%b num=%h r0=%b r1=%b cnt=%0d exp all 0",
               gnt, busy, done, cmp_num, res0, res1, srv_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({done, res0, busy} !== 6'd0) begin
        bad++;
        $display("FAIL rstmid_nodone%0d got done=%b r0=%b busy=%b exp 00 000 0", c, done, res0, busy);
      end
    end
    num0 = 4'd6; req = 2'b01;
    step(); req = '0; step(); step();
    total++;
    if ({done, res0, srv_cnt} !== {2'b01, 3'b101, 8'd1}) begin
      bad++;
      $display("FAIL rstmid_after got done=%b r0=%b cnt=%0d exp 01 101 1", done, res0, srv_cnt);
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    do_reset();
    num0 = 4'd6; req = 2'b01;
    for (int c = 0; c < 256 * 4 + 20 && k < 256; c++) begin
      step();
      if (done == 2'b01) begin
        k++;
        total++;
        if ({srv_cnt, busy} !== {8'(k), 1'b0}) begin
          bad++;
          $display("FAIL wrap_op%0d got cnt=%0d busy=%b exp %0d 0", k, srv_cnt, busy, k % 256);
        end
      end
    end
    req = '0;
    total++;
    if (k != 256) begin
      bad++;
      $display("FAIL wrap_timeout got ops=%0d exp=256", k);
    end
    step();
    total++;
    if ({srv_cnt, busy} !== 9'd0) begin
      bad++;
      $display("FAIL wrap_final got cnt=%0d busy=%b exp 0 0", srv_cnt, busy);
    end
  endtask

  // Reference: each operation is a scheduled transaction launched in cycle g,
  // granted over cycles g+1..g+S+1 and completing (DONE/RES) in cycle g+S+2.
  task automatic test_random();
    localparam int S = 1;
    int         g = -100;
    logic       owner = 1'b0, mlast = 1'b1;
    logic [3:0] mop = '0;
    logic [2:0] mres [2];
    logic [7:0] mcnt = '0;
    logic [1:0] edone, egnt, elig;
    logic       in_op;
    mres[0] = '0; mres[1] = '0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      edone = 2'b00;
      if (c == g + S + 2) begin
        mres[owner] = tbl[mop];
        mcnt++;
        mlast = owner;
        edone = owner ? 2'b10 : 2'b01;
      end
      in_op = (c >= g + 1) && (c <= g + S + 1);
      egnt  = in_op ? (owner ? 2'b10 : 2'b01) : 2'b00;
      total++;
      if ({gnt, busy, cmp_num, done, res0, res1, srv_cnt} !==
          {egnt, in_op, mop, edone, mres[0], mres[1], mcnt}) begin
        bad++;
        $display("FAIL random_c%0d got gnt=%b busy=%b num=%h done=%b r0=%b r1=%b cnt=%0d exp gnt=%b busy=%b num=%h done=%b r0=%b r1=%b cnt=%0d",
                 c, gnt, busy, cmp_num, done, res0, res1, srv_cnt,
                 egnt, in_op, mop, edone, mres[0], mres[1], mcnt);
      end
      req  = 2'($urandom_range(0, 3));
      num0 = 4'($urandom);
      num1 = 4'($urandom);
      elig = req & ~edone;
      if (!in_op && elig != 2'b00) begin
        owner = (elig == 2'b11) ? !mlast : elig[1];
        mop   = owner ? num1 : num0;
        g     = c;
      end
      step();
    end
    req = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = 3'($urandom);
    tbl[0] = 3'b010;
    tbl[6] = 3'b101;
    rst = 1'b1; req = '0; num0 = '0; num1 = '0;
    req_s = '0; num0_s = '0; num1_s = '0; glitch_s = 1'b0; junk = '0;
    step();
    test_reset();
    test_single();
    test_tie();
    test_settle();
    test_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
